// File: rtl/timing_sequencer.sv
// One-hot phase sequencer: PHASES phases of a latched width, optional loop, abort.
// Define TIMING_SEQ_GAP_EN to insert one idle GAP cycle between phases and at the loop wrap.
module timing_sequencer #(
  parameter int PHASES = 4,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sta,
  input  logic              abort,
  input  logic              loop,
  input  logic [CNT_W-1:0]  width,
  output logic [PHASES-1:0] q,
  output logic [IDX_W-1:0]  phase,
  output logic              busy,
  output logic              done
);

`ifdef TIMING_SEQ_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd3} state_t;
`endif

  localparam logic [IDX_W-1:0]  LAST = IDX_W'(PHASES - 1);
  localparam logic [PHASES-1:0] ONE  = PHASES'(1);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   w_lat, w_n;
  logic [CNT_W-1:0]   w_start;
  logic               sta_q;
  logic               start_ev;

  assign start_ev = sta & ~sta_q;
  assign w_start  = (width == '0) ? CNT_W'(1) : width;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      w_lat <= '0;
      sta_q <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      w_lat <= w_n;
      sta_q <= sta;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    w_n     = w_lat;
    case (state)
      IDLE: begin
        if (start_ev && !abort) begin
          state_n = RUN;
          idx_n   = '0;
          cnt_n   = '0;
          w_n     = w_start;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (cnt == w_lat - CNT_W'(1)) begin
          cnt_n = '0;
          // Entering GAP already carries the next index so phase shows it during the gap.
          if (idx != LAST) begin
            idx_n = idx + IDX_W'(1);
`ifdef TIMING_SEQ_GAP_EN
            state_n = GAP;
`endif
          end else if (loop) begin
            idx_n = '0;
            w_n   = w_start;
`ifdef TIMING_SEQ_GAP_EN
            state_n = GAP;
`endif
          end else begin
            idx_n   = '0;
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`ifdef TIMING_SEQ_GAP_EN
      GAP: begin
        if (abort) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          state_n = RUN;
        end
      end
`endif
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  assign q     = (state == RUN) ? (ONE << idx) : '0;
  assign phase = idx;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer (PHASES=4, CNT_W=8); follows TIMING_SEQ_GAP_EN if defined.
module tb_timing_sequencer;
  localparam int PHASES = 4;
  localparam int CNT_W  = 8;
  localparam int IDX_W  = 4;
`ifdef TIMING_SEQ_GAP_EN
  localparam bit GAP_MODE = 1'b1;
`else
  localparam bit GAP_MODE = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              sta;
  logic              abort;
  logic              loop;
  logic [CNT_W-1:0]  width;
  logic [PHASES-1:0] q;
  logic [IDX_W-1:0]  phase;
  logic              busy;
  logic              done;

  int checks;
  int fails;

  timing_sequencer #(.PHASES(PHASES), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .sta(sta), .abort(abort), .loop(loop),
    .width(width), .q(q), .phase(phase), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] obs_vec();
    return {q, phase, busy, done};
  endfunction

  // Expected {q, phase, busy, done} for cycle c after the start edge (c=1 is first active cycle).
  function automatic logic [9:0] exp_vec(int c, int w, bit wrap);
    int per, len, k, pos;
    per = GAP_MODE ? w + 1 : w;
    len = PHASES * per - (GAP_MODE ? 1 : 0);
    if (c >= 1 && c <= len) begin
      k   = (c - 1) / per;
      pos = (c - 1) % per;
      if (pos == w) return {4'b0000, 4'(k + 1), 1'b1, 1'b0};
      return {4'(1 << k), 4'(k), 1'b1, 1'b0};
    end
    if (c == len + 1) begin
      if (wrap) return {4'b0000, 4'd0, 1'b1, 1'b0};
      return {4'b0000, 4'd0, 1'b1, 1'b1};
    end
    return 10'd0;
  endfunction

  function automatic int seq_len(int w);
    return GAP_MODE ? PHASES * (w + 1) - 1 : PHASES * w;
  endfunction

  task automatic idle_gap();
    @(negedge clk);
    sta = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] o;
    rst_n = 1'b0; sta = 1'b0; abort = 1'b0; loop = 1'b0; width = 8'd3;
    #2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = obs_vec();
      checks++;
      if (o !== 10'd0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, o, 10'd0);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    o = obs_vec();
    checks++;
    if (o !== 10'd0) begin
      fails++;
      $display("FAIL reset_release: got %b expected %b", o, 10'd0);
    end
  endtask

  // width=3; sta dropped and re-raised mid-run, width changed mid-run, sta held through DONE.
  task automatic test_basic();
    logic [9:0] o, e;
    idle_gap();
    width = 8'd3; sta = 1'b1;
    for (int c = 1; c <= seq_len(3) + 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = obs_vec();
      e = exp_vec(c, 3, 1'b0);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL basic cycle %0d: got %b expected %b", c, o, e);
      end
      if (c == 2) sta = 1'b0;
      if (c == 4) sta = 1'b1;
      if (c == 5) width = 8'd7;
    end
  endtask

  task automatic test_width_zero();
    logic [9:0] o, e;
    idle_gap();
    width = 8'd0; sta = 1'b1;
    for (int c = 1; c <= seq_len(1) + 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = obs_vec();
      e = exp_vec(c, 1, 1'b0);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL width0 cycle %0d: got %b expected %b", c, o, e);
      end
    end
  endtask

  task automatic test_width_max();
    logic [9:0] o, e;
    idle_gap();
    width = 8'd255; sta = 1'b1;
    for (int c = 1; c <= seq_len(255) + 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = obs_vec();
      e = exp_vec(c, 255, 1'b0);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL width_max cycle %0d: got %b expected %b", c, o, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [9:0] o, e;
    idle_gap();
    width = 8'd5; sta = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = obs_vec();
      e = (c <= 7) ? exp_vec(c, 5, 1'b0) : 10'd0;
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL abort cycle %0d: got %b expected %b", c, o, e);
      end
      if (c == 7) abort = 1'b1;
      if (c == 8) abort = 1'b0;
    end
    idle_gap();
    sta = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = obs_vec();
      e = exp_vec(c, 5, 1'b0);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL abort_restart cycle %0d: got %b expected %b", c, o, e);
      end
    end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_loop();
    logic [9:0] o, e;
    int p;
    p = GAP_MODE ? seq_len(2) + 1 : seq_len(2);
    idle_gap();
    width = 8'd2; loop = 1'b1; sta = 1'b1;
    for (int c = 1; c <= 2 * p + 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = obs_vec();
      e = (c <= p) ? exp_vec(c, 2, 1'b1) : exp_vec(c - p, 2, 1'b0);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL loop cycle %0d: got %b expected %b", c, o, e);
      end
      if (c == p + 2) loop = 1'b0;
    end
  endtask

  task automatic test_start_abort_idle();
    logic [9:0] o;
    idle_gap();
    width = 8'd2; sta = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      o = obs_vec();
      checks++;
      if (o !== 10'd0) begin
        fails++;
        $display("FAIL start_abort_idle cycle %0d: got %b expected %b", c, o, 10'd0);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] o, e;
    idle_gap();
    width = 8'd4; sta = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = obs_vec();
      e = exp_vec(c, 4, 1'b0);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL async_pre cycle %0d: got %b expected %b", c, o, e);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    o = obs_vec();
    checks++;
    if (o !== 10'd0) begin
      fails++;
      $display("FAIL async_reset_immediate: got %b expected %b", o, 10'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = obs_vec();
      e = exp_vec(c, 4, 1'b0);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL start_after_reset cycle %0d: got %b expected %b", c, o, e);
      end
    end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic();
    test_width_zero();
    test_abort();
    test_loop();
    test_start_abort_idle();
    test_async_reset();
    test_width_max();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/timing_sequencer.md
TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 Parameter PHASES, default 4: number of sequential phase outputs; legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the phase-length input and of the internal cycle counter.
REQ-003 Parameter IDX_W, default 4: width of the phase index output; must satisfy 2^IDX_W >= PHASES.
REQ-004 The block shall have one clock; reset shall be asynchronous and active-low.
REQ-005 Port clk, input, 1: sole clock; all state changes occur on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port sta, input, 1: start request; only a 0->1 transition sampled on clk is acted on.
REQ-008 Port abort, input, 1: synchronous cancel of a running sequence.
REQ-009 Port loop, input, 1: when high at sequence end, the sequence restarts.
REQ-010 Port width, input, CNT_W: phase length in clk cycles; latched at start.
REQ-011 Port q, output, PHASES: one-hot phase pulses; all zero when idle.
REQ-012 Port phase, output, IDX_W: index of the active phase; 0 when idle.
REQ-013 Port busy, output, 1: high while a sequence is running.
REQ-014 Port done, output, 1: single-cycle pulse when a sequence completes normally.

Function
REQ-015 States shall be IDLE, RUN, GAP and DONE; GAP shall exist only per REQ-032.
REQ-016 sta shall be registered once; a start event is sta==1 with the registered copy ==0.
REQ-017 In IDLE, a start event at edge E0 shall enter RUN with q[0]=1, busy=1 and phase=0 in the cycle following E0.
REQ-018 At start, width shall be latched as W; width==0 shall be latched as 1. Later changes to width shall not affect the running sequence.
REQ-019 Each phase shall keep its q bit high for exactly W consecutive cycles; at most one q bit shall ever be high.
REQ-020 After W cycles of phase k < PHASES-1, phase k+1 shall become active on the next cycle, unless GAP applies.
REQ-021 After the last phase, if loop==1 and abort==0, phase 0 shall restart; W shall be re-latched from width; done shall not pulse.
REQ-022 After the last phase with loop==0, the block shall go to DONE for one cycle: q=0, done=1, busy=1. It shall then return to IDLE with busy=0.
REQ-023 abort==1 at any edge in RUN, GAP or DONE shall force IDLE on the next cycle: q=0, busy=0, phase=0, no done pulse. abort has highest priority.
REQ-024 Start events while not in IDLE shall be ignored and not queued.
REQ-025 A start event and abort at the same edge in IDLE shall not start a sequence.
REQ-026 sta held high through DONE shall not restart; a new 0->1 transition is required.
REQ-027 Counter arithmetic shall be unsigned CNT_W bits; W = 2^CNT_W - 1 shall run fully without wrap error.

Reset
REQ-028 While rst_n==0: q=0, phase=0, busy=0, done=0, state=IDLE, and the counter and registered sta shall be 0.
REQ-029 Assertion of rst_n mid-sequence shall clear all outputs immediately, without waiting for clk.
REQ-030 After rst_n deasserts, sta already high shall count as a start event on the first clk edge.

Configuration
REQ-031 Macro TIMING_SEQ_GAP_EN selects the phase-gap feature.
REQ-032 With TIMING_SEQ_GAP_EN defined, one GAP cycle with q=0, busy=1 and phase holding the next index shall separate consecutive phases and the loop wrap. Sequence length is PHASES*W + PHASES-1 cycles.
REQ-033 With TIMING_SEQ_GAP_EN undefined, phases shall be back-to-back. Sequence length is PHASES*W cycles, and no GAP state shall exist.

Verification (PHASES=4, CNT_W=8, macro undefined unless stated)
REQ-034 width=3, sta 0->1 at edge 0 -> q[0] high in cycles 1-3, q[1] 4-6, q[2] 7-9, q[3] 10-12, done=1 in cycle 13, busy=0 from cycle 14.
REQ-035 width=0, single start -> each q bit high for exactly 1 cycle, done in cycle 5.
REQ-036 width=5, abort=1 at cycle 7 (q[1] active) -> q=0 and busy=0 from cycle 8, done never pulses; a new sta edge restarts from q[0].
REQ-037 width=2, loop=1 held -> q[3] in cycles 7-8 followed directly by q[0] in cycles 9-10, no done; loop=0 then gives done after the next q[3].
REQ-038 width=4, rst_n low mid-phase 2 -> all outputs 0 immediately, before the next clk edge.
REQ-039 TIMING_SEQ_GAP_EN defined, width=2 -> q[0] in cycles 1-2, gap in cycle 3, q[1] in cycles 4-5, …, q[3] in cycles 10-11, done in cycle 12.
